// File: rtl/router_in_buffer.sv
// Input-port flit buffer: DEPTH-entry circular FIFO, first-word-fall-through head, occupancy exported as pressure.
// Optional statistics (high-water mark, sticky overflow flag) are built when RIB_STATS_EN is defined.
module router_in_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned DATASIZE = 40
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] link_data,
    input  logic                link_valid,
    output logic                link_ready,
    output logic [DATASIZE-1:0] rc_data,
    output logic                rc_valid,
    input  logic                rc_ready,
`ifdef RIB_STATS_EN
    output logic [WIDTH:0]      stat_hwm,
    output logic                stat_ovf,
`endif
    output logic [WIDTH:0]      pressure_out
);

    localparam int unsigned CNT_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_c, pop_c;

    // Handshake status depends on stored occupancy only; a same-cycle pop never frees a slot.
    assign link_ready   = (count_q != FULL_CNT);
    assign rc_valid     = (count_q != '0);
    assign rc_data      = mem_q[rd_ptr_q];
    assign pressure_out = count_q;

    assign push_c = link_valid & link_ready;
    assign pop_c  = rc_valid & rc_ready;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + WIDTH'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + WIDTH'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is deliberately unreset; contents are masked by rc_valid.
    always_ff @(posedge rc_clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= link_data;
        end
    end

`ifdef RIB_STATS_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;
    logic             ovf_q, ovf_d;

    // High-water mark tracks post-edge occupancy; overflow is any offer against a full buffer.
    always_comb begin
        hwm_d = hwm_q;
        ovf_d = ovf_q;
        if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
        if (link_valid && (count_q == FULL_CNT)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            hwm_q <= hwm_d;
            ovf_q <= ovf_d;
        end
    end

    assign stat_hwm = hwm_q;
    assign stat_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_router_in_buffer.sv
// Directed self-checking bench for router_in_buffer; statistics checks compile in with RIB_STATS_EN.
module tb_router_in_buffer;

    logic        rc_clk;
    logic        rst_n;
    logic [39:0] link_data;
    logic        link_valid;
    logic        link_ready;
    logic [39:0] rc_data;
    logic        rc_valid;
    logic        rc_ready;
    logic [3:0]  pressure_out;
`ifdef RIB_STATS_EN
    logic [3:0]  stat_hwm;
    logic        stat_ovf;
`endif

    int checks = 0;
    int errors = 0;

    router_in_buffer #(.DEPTH(8), .WIDTH(3), .DATASIZE(40)) dut (
        .rc_clk       (rc_clk),
        .rst_n        (rst_n),
        .link_data    (link_data),
        .link_valid   (link_valid),
        .link_ready   (link_ready),
        .rc_data      (rc_data),
        .rc_valid     (rc_valid),
        .rc_ready     (rc_ready),
`ifdef RIB_STATS_EN
        .stat_hwm     (stat_hwm),
        .stat_ovf     (stat_ovf),
`endif
        .pressure_out (pressure_out)
    );

    initial rc_clk = 1'b0;
    always #5 rc_clk = ~rc_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rc_clk);
        #1;
    endtask

    function automatic logic [39:0] flit(input int i);
        return {4'(i), 4'(7 - i), 8'(i * 3), 22'(i + 100), 2'(i)};
    endfunction

    initial begin
        rst_n      = 1'b0;
        link_valid = 1'b0;
        link_data  = '0;
        rc_ready   = 1'b0;
        #23 rst_n = 1'b1;
        tick();

        // Idle after reset
        check("rst_link_ready", 64'(link_ready), 64'd1);
        check("rst_rc_valid", 64'(rc_valid), 64'd0);
        check("rst_pressure", 64'(pressure_out), 64'd0);
`ifdef RIB_STATS_EN
        check("rst_hwm", 64'(stat_hwm), 64'd0);
        check("rst_ovf", 64'(stat_ovf), 64'd0);
`endif

        // Single flit, one-cycle latency, then pop
        link_data  = 40'h1_2_0A_00001_1;
        link_valid = 1'b1;
        tick();
        link_valid = 1'b0;
        check("one_valid", 64'(rc_valid), 64'd1);
        check("one_data", 64'(rc_data), 64'h120A000011);
        check("one_pressure", 64'(pressure_out), 64'd1);
        rc_ready = 1'b1;
        tick();
        rc_ready = 1'b0;
        check("one_pop_valid", 64'(rc_valid), 64'd0);
        check("one_pop_pressure", 64'(pressure_out), 64'd0);

        // Fill to capacity, offer a ninth flit
        for (int i = 0; i < 8; i++) begin
            link_data  = flit(i);
            link_valid = 1'b1;
            tick();
        end
        check("full_pressure", 64'(pressure_out), 64'd8);
        check("full_link_ready", 64'(link_ready), 64'd0);
        link_data = 40'hDE_ADBE_EF00;
        tick();
        link_valid = 1'b0;
        check("ovf_pressure", 64'(pressure_out), 64'd8);
        check("ovf_head", 64'(rc_data), 64'(flit(0)));
`ifdef RIB_STATS_EN
        check("ovf_flag", 64'(stat_ovf), 64'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_data_%0d", i), 64'(rc_data), 64'(flit(i)));
            rc_ready = 1'b1;
            tick();
        end
        rc_ready = 1'b0;
        check("drain_valid", 64'(rc_valid), 64'd0);
        check("drain_pressure", 64'(pressure_out), 64'd0);
`ifdef RIB_STATS_EN
        check("drain_ovf_sticky", 64'(stat_ovf), 64'd1);
        check("drain_hwm", 64'(stat_hwm), 64'd8);
`endif

        // Full with simultaneous offer and pop: only the pop happens
        for (int i = 0; i < 8; i++) begin
            link_data  = flit(i + 8);
            link_valid = 1'b1;
            tick();
        end
        link_data = 40'hAB_CDEF_0123;
        rc_ready  = 1'b1;
        tick();
        link_valid = 1'b0;
        rc_ready   = 1'b0;
        check("fullpop_pressure", 64'(pressure_out), 64'd7);
        check("fullpop_link_ready", 64'(link_ready), 64'd1);
        check("fullpop_head", 64'(rc_data), 64'(flit(9)));

        // Reset pulse clears everything, including statistics
        rst_n = 1'b0;
        #1;
        check("pulse_pressure", 64'(pressure_out), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Streaming with both sides ready: steady occupancy of one
        link_valid = 1'b1;
        rc_ready   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            link_data = flit(k + 32);
            tick();
            check($sformatf("stream_data_%0d", k), 64'(rc_data), 64'(flit(k + 32)));
            check($sformatf("stream_pressure_%0d", k), 64'(pressure_out), 64'd1);
        end
        link_valid = 1'b0;
        tick();
        rc_ready = 1'b0;
        check("stream_end_pressure", 64'(pressure_out), 64'd0);
`ifdef RIB_STATS_EN
        check("stream_hwm", 64'(stat_hwm), 64'd1);
        check("stream_ovf", 64'(stat_ovf), 64'd0);
`endif

        // Asynchronous reset with five flits stored
        for (int i = 0; i < 5; i++) begin
            link_data  = flit(i + 60);
            link_valid = 1'b1;
            tick();
        end
        link_valid = 1'b0;
        check("five_pressure", 64'(pressure_out), 64'd5);
        rst_n = 1'b0;
        #1;
        check("async_pressure", 64'(pressure_out), 64'd0);
        check("async_valid", 64'(rc_valid), 64'd0);
        check("async_link_ready", 64'(link_ready), 64'd1);
`ifdef RIB_STATS_EN
        check("async_hwm", 64'(stat_hwm), 64'd0);
`endif
        @(negedge rc_clk);
        rst_n = 1'b1;
        tick();
        link_data  = 40'h5_3_77_2AAAA_2;
        link_valid = 1'b1;
        tick();
        link_valid = 1'b0;
        check("post_rst_valid", 64'(rc_valid), 64'd1);
        check("post_rst_data", 64'(rc_data), 64'h53772AAAA2);
        check("post_rst_pressure", 64'(pressure_out), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_in_buffer.md
# router_in_buffer

Input-port flit buffer for one mesh router port. Accepts 40-bit flits from the upstream link with a valid/ready handshake and stores them in a DEPTH-entry circular FIFO. Presents the head flit first-word-fall-through to the downstream route-computation stage (rc_10_sub-style `data_in`/`valid_in`/`rc_ready`). Exports its occupancy as the pressure value that neighbouring route-computation stages use for adaptive East/North/South selection.

## Interface
- `DEPTH`, 8: number of flit entries; must equal 2^`WIDTH`.
- `WIDTH`, 3: pointer width; pressure and count are `WIDTH`+1 bits.
- `DATASIZE`, 40: flit width. Fields: src [39:36], dst [35:32], timestamp [31:24], data [23:2], type [1:0].

Ports:
- `rc_clk`  in  1  clock (already decided); all state changes on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low (already decided).
- `link_data`  in  DATASIZE  flit from the upstream router.
- `link_valid`  in  1  upstream flit valid.
- `link_ready`  out  1  buffer can accept a flit this cycle.
- `rc_data`  out  DATASIZE  head flit; drives route computation `data_in`.
- `rc_valid`  out  1  head flit valid; drives route computation `valid_in`.
- `rc_ready`  in  1  route computation consumes the head flit this edge.
- `pressure_out`  out  WIDTH+1  current occupancy, 0..DEPTH.
- `stat_hwm`  out  WIDTH+1  occupancy high-water mark (only with `RIB_STATS_EN`).
- `stat_ovf`  out  1  sticky overflow-attempt flag (only with `RIB_STATS_EN`).

## Operation
- State: `mem[DEPTH]`, `wr_ptr` and `rd_ptr` (`WIDTH` bits each, natural wrap DEPTH-1 -> 0), `count` (`WIDTH`+1 bits).
- push = `link_valid` & `link_ready`. At the edge, writes `link_data` to `mem[wr_ptr]` and increments `wr_ptr`.
- pop = `rc_valid` & `rc_ready`. At the edge, increments `rd_ptr`.
- `count` update: push only, +1; pop only, -1; both or neither, unchanged.
- `link_ready` = (`count` != DEPTH). This is combinational from state only, so a pop in the same cycle does not make room. A full buffer rejects the flit for that cycle.
- `rc_valid` = (`count` != 0). `rc_data` = `mem[rd_ptr]`, combinational read with no output register.
- Empty buffer: a pushed flit becomes visible on `rc_data`/`rc_valid` the cycle after the push. There is no same-cycle bypass.
- Contents are passed through unmodified.
- `pressure_out` = `count`.
- `rc_ready` while `rc_valid`=0 has no effect.
- `link_valid` while full is ignored. The flit stays on the upstream side.

## Timing
- Reset values (asynchronous): `wr_ptr`=0, `rd_ptr`=0, `count`=0, `link_ready`=1, `rc_valid`=0, `pressure_out`=0, `stat_hwm`=0, `stat_ovf`=0.
- `mem` is not reset. While `rc_valid`=0, `rc_data` is don't-care.
- Latency, link to rc: 1 cycle (push at edge N, `rc_valid`=1 after edge N).
- Throughput: 1 push and 1 pop per cycle sustained whenever 0 < `count` < DEPTH.
- Reset asserted mid-operation: all stored flits are discarded immediately and outputs take their reset values. There is no handshake with upstream.

## Configuration
- `RIB_STATS_EN` defined:
  - `stat_hwm` registers max(`stat_hwm`, next `count`) every edge.
  - `stat_ovf` sets and stays 1 at any edge where `link_valid`=1 and `count`=DEPTH; it clears only on reset.
- `RIB_STATS_EN` undefined: the `stat_hwm` and `stat_ovf` ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle -> `link_ready`=1, `rc_valid`=0, `pressure_out`=0.
- Push one flit 40'h1_2_0A_00001_1 with `rc_ready`=0 -> next cycle `rc_valid`=1, `rc_data`=that flit, `pressure_out`=1. Assert `rc_ready` for one cycle -> `rc_valid`=0, `pressure_out`=0.
- Push 8 flits with `rc_ready`=0 -> `pressure_out`=8, `link_ready`=0. A 9th `link_valid` is not stored, and `stat_ovf`=1 when the macro is enabled. Pop all 8 -> output order matches input order.
- Full buffer with `link_valid`=1 and `rc_ready`=1 simultaneously -> the pop occurs, the push does not, `pressure_out`=7. Next cycle `link_ready`=1.
- Stream 20 flits with both sides always ready -> 1 flit per cycle, `pressure_out` steady at 1, pointers wrap, data in order, `stat_hwm`=1.
- Assert `rst_n` low with 5 flits stored -> `pressure_out`=0 and `rc_valid`=0 immediately. After release, a new push is read back correctly.
